// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//
// N-stage CIC decimation filter. Integrators run at the input sample rate and
// advance only on accepted samples. A phase counter picks every R-th sample,
// and a comb chain running at the output rate differences the decimated
// integrator value N times. All arithmetic is W-bit two's complement and wraps
// on overflow. This wrap is what makes the CIC exact: the final differences
// are correct modulo 2^W, and W is large enough to hold the true output.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, clears every register
//   in_valid   input sample strobe (no backpressure)
//   in_data    signed input sample, IN_W bits
//   out_valid  one-cycle strobe, once per R accepted samples
//   out_data   signed full-precision output, W bits, held between strobes
// -----------------------------------------------------------------------------
module cic_decimator #(
    parameter  int IN_W = 10,
    parameter  int N    = 3,
    parameter  int R    = 8,
    localparam int W    = IN_W + N * $clog2(R)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] in_data,
    output logic                   out_valid,
    output logic signed [W-1:0]    out_data
);

    localparam int               CNT_W    = $clog2(R);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

    logic signed [W-1:0] in_ext_s;
    logic signed [W-1:0] integ_r [N];
    logic [CNT_W-1:0]    cnt_r;
    logic                samp_v_r;
    logic signed [W-1:0] dly_r   [N];
    logic signed [W-1:0] comb_r  [N];
    logic [N-1:0]        vld_r;
    logic signed [W-1:0] cx_s    [N];
    logic [N-1:0]        cv_s;

    // Sign-extend the incoming sample to the internal width.
    always_comb begin
        in_ext_s = {{(W-IN_W){in_data[IN_W-1]}}, in_data};
    end

    // Integrator chain. Each stage adds the pre-edge value of the stage before
    // it, so the chain is pipelined with one register per stage. As a result,
    // stage N lags the first stage by N-1 accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                integ_r[k] <= '0;
            end
        end else if (in_valid) begin
            integ_r[0] <= integ_r[0] + in_ext_s;
            for (int k = 1; k < N; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                integ_r[k] <= integ_r[k];
            end
        end
    end

    // Decimation phase counter and sample strobe. The strobe is registered, so
    // it is high in the cycle after the R-th accepted sample. In that cycle the
    // last integrator already holds that sample's update. Gaps in in_valid only
    // pause the counter, so they never change the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            samp_v_r <= 1'b0;
        end else begin
            samp_v_r <= in_valid && (cnt_r == CNT_LAST);
            if (in_valid) begin
                if (cnt_r == CNT_LAST) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Select each comb stage's input. The first stage takes the last integrator
    // and the sample strobe. Every later stage takes the previous comb stage.
    always_comb begin
        cx_s[0] = integ_r[N-1];
        cv_s    = '0;
        cv_s[0] = samp_v_r;
        for (int k = 1; k < N; k++) begin
            cx_s[k] = comb_r[k-1];
            cv_s[k] = vld_r[k-1];
        end
    end

    // Comb chain. On its strobe, each stage outputs the difference between its
    // input and the input it latched on its previous strobe. The valid bits form
    // a pure shift register, so results already in flight are never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                dly_r[k]  <= '0;
                comb_r[k] <= '0;
            end
            vld_r <= '0;
        end else begin
            vld_r <= cv_s;
            for (int k = 0; k < N; k++) begin
                if (cv_s[k]) begin
                    comb_r[k] <= cx_s[k] - dly_r[k];
                    dly_r[k]  <= cx_s[k];
                end else begin
                    comb_r[k] <= comb_r[k];
                    dly_r[k]  <= dly_r[k];
                end
            end
        end
    end

    // The outputs come straight from the last comb stage's registers.
    always_comb begin
        out_valid = vld_r[N-1];
        out_data  = comb_r[N-1];
    end

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//
// Self-checking bench for cic_decimator. It instantiates four configurations:
// the default (10,3,8) and the (8,1,2), (12,5,16) and (10,4,10) variants.
//
// The reference model works on whole sample streams:
//   1. take the N-fold running sum of the accepted samples;
//   2. delay it by N-1 samples;
//   3. pick every R-th value;
//   4. take the N-fold first difference, starting from zero history;
//   5. reduce the result to a signed W-bit value.
// -----------------------------------------------------------------------------
module tb_cic_decimator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic               v0 = 1'b0, v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic signed [9:0]  d0 = '0;
    logic signed [7:0]  d1 = '0;
    logic signed [11:0] d2 = '0;
    logic signed [9:0]  d3 = '0;
    logic               ov0, ov1, ov2, ov3;
    logic signed [18:0] od0;
    logic signed [8:0]  od1;
    logic signed [31:0] od2;
    logic signed [25:0] od3;

    cic_decimator #(.IN_W(10), .N(3), .R(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_data(d0), .out_valid(ov0), .out_data(od0));
    cic_decimator #(.IN_W(8), .N(1), .R(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_data(d1), .out_valid(ov1), .out_data(od1));
    cic_decimator #(.IN_W(12), .N(5), .R(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .out_valid(ov2), .out_data(od2));
    cic_decimator #(.IN_W(10), .N(4), .R(10)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .out_valid(ov3), .out_data(od3));

    int checks   = 0;
    int failures = 0;

    int sel = 0;
    int cn  = 3;
    int cr  = 8;
    int cw  = 19;
    int ciw = 10;

    longint xs[$];
    longint got[$];
    longint ex[$];
    longint gq[$];

    // Collect every output strobe of all instances, sampled away from the active edge.
    always @(negedge clk) begin
        if (ov0) got.push_back(longint'(od0));
        if (ov1) got.push_back(longint'(od1));
        if (ov2) got.push_back(longint'(od2));
        if (ov3) got.push_back(longint'(od3));
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic select_cfg(input int s);
        sel = s;
        case (s)
            0: begin cn = 3; cr = 8;  cw = 19; ciw = 10; end
            1: begin cn = 1; cr = 2;  cw = 9;  ciw = 8;  end
            2: begin cn = 5; cr = 16; cw = 32; ciw = 12; end
            default: begin cn = 4; cr = 10; cw = 26; ciw = 10; end
        endcase
    endtask

    function automatic longint rnd(input int iw);
        longint u;
        u = longint'($urandom_range(0, (32'd1 << iw) - 32'd1));
        if (u >= (64'sd1 << (iw - 1))) u -= (64'sd1 << iw);
        return u;
    endfunction

    // Drive one cycle on the selected instance; accepted samples join the stream.
    task automatic step(input bit v, input longint d);
        longint dd;
        dd = d;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        case (sel)
            0: begin v0 = v; d0 = dd[9:0];  end
            1: begin v1 = v; d1 = dd[7:0];  end
            2: begin v2 = v; d2 = dd[11:0]; end
            default: begin v3 = v; d3 = dd[9:0]; end
        endcase
        @(posedge clk);
        #1;
        if (v) xs.push_back(d);
    endtask

    task automatic reset_dut();
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        xs.delete();
        got.delete();
    endtask

    task automatic flush();
        repeat (cn + 4) step(1'b0, 64'sd0);
    endtask

    // Build the expected output list from the accepted-sample stream.
    task automatic run_model();
        longint a[$];
        longint y[$];
        longint acc, t, msk;
        int     m, idx;
        a = xs;
        for (int s = 0; s < cn; s++) begin
            acc = 0;
            for (int i = 0; i < a.size(); i++) begin
                acc += a[i];
                a[i] = acc;
            end
        end
        m = a.size() / cr;
        y.delete();
        for (int k = 0; k < m; k++) begin
            idx = k * cr + cr - 1 - (cn - 1);
            y.push_back((idx >= 0) ? a[idx] : 64'sd0);
        end
        for (int s = 0; s < cn; s++) begin
            acc = 0;
            for (int k = 0; k < m; k++) begin
                t    = y[k];
                y[k] = t - acc;
                acc  = t;
            end
        end
        ex.delete();
        msk = (64'sd1 << cw) - 64'sd1;
        for (int k = 0; k < m; k++) begin
            t = y[k] & msk;
            if (t[cw-1]) t -= (64'sd1 << cw);
            ex.push_back(t);
        end
    endtask

    task automatic compare_model(input string tag);
        run_model();
        chk({tag, "_count"}, longint'(got.size()), longint'(ex.size()));
        for (int k = 0; k < ex.size() && k < got.size(); k++) begin
            chk($sformatf("%s[%0d]", tag, k), got[k], ex[k]);
        end
    endtask

    task automatic dc_run(input string tag, input longint val, input int nsamp, input longint dc_exp);
        reset_dut();
        repeat (nsamp) step(1'b1, val);
        flush();
        compare_model(tag);
        for (int k = 4; k < got.size(); k++) begin
            chk($sformatf("%s_dc[%0d]", tag, k), got[k], dc_exp);
        end
    endtask

    initial begin
        longint sum;

        // Reset held: random activity must not reach the outputs.
        select_cfg(0);
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom_range(0, 1)), rnd(10));
            @(negedge clk);
            chk("rst_ov0", longint'(ov0), 64'sd0);
            chk("rst_od0", longint'(od0), 64'sd0);
            chk("rst_ov2", longint'(ov2), 64'sd0);
            chk("rst_od2", longint'(od2), 64'sd0);
        end
        rst = 1'b0;
        xs.delete();
        got.delete();

        // Latency: out_valid is high exactly in the cycle after edge t+N.
        repeat (8) step(1'b1, 64'sd1);
        for (int e = 1; e <= 5; e++) begin
            step(1'b0, 64'sd0);
            @(negedge clk);
            chk($sformatf("lat_e%0d", e), longint'(ov0), (e == 3) ? 64'sd1 : 64'sd0);
        end
        compare_model("lat");

        // DC gain checks, defaults.
        dc_run("dc_pos", 64'sd511, 80, 64'sd261632);
        dc_run("dc_neg", -64'sd512, 80, -64'sd262144);
        dc_run("dc_one", 64'sd1, 80, 64'sd512);

        // Impulse at every decimation phase.
        for (int p = 0; p < 8; p++) begin
            reset_dut();
            for (int i = 0; i < 64; i++) step(1'b1, (i == p) ? 64'sd1 : 64'sd0);
            flush();
            compare_model($sformatf("imp%0d", p));
            sum = 0;
            for (int k = 0; k < got.size(); k++) sum += got[k];
            chk($sformatf("imp%0d_sum", p), sum, 64'sd64);
            for (int k = 4; k < got.size(); k++) begin
                chk($sformatf("imp%0d_tail[%0d]", p, k), got[k], 64'sd0);
            end
        end

        // Long full-scale run: the integrators wrap many times.
        dc_run("wrap", 64'sd511, 10240, 64'sd261632);

        // Gapped random input, then the same samples fed without gaps.
        reset_dut();
        for (int i = 0; i < 300; i++) step($urandom_range(0, 9) < 3, rnd(10));
        flush();
        compare_model("gap");
        gq = got;
        ex = xs;
        reset_dut();
        for (int i = 0; i < ex.size(); i++) step(1'b1, ex[i]);
        flush();
        chk("contig_count", longint'(got.size()), longint'(gq.size()));
        for (int k = 0; k < gq.size() && k < got.size(); k++) begin
            chk($sformatf("contig[%0d]", k), got[k], gq[k]);
        end

        // Reset while the comb valids are in flight: no stray strobe.
        reset_dut();
        for (int i = 0; i < 10; i++) step(1'b1, rnd(10));
        rst = 1'b1;
        repeat (3) step(1'b1, rnd(10));
        rst = 1'b0;
        chk("midrst_inflight", longint'(got.size()), 64'sd0);
        // Reset 3 samples into a period: the partial phase count is discarded.
        for (int i = 0; i < 3; i++) step(1'b1, rnd(10));
        rst = 1'b1;
        step(1'b0, 64'sd0);
        rst = 1'b0;
        xs.delete();
        chk("midrst_partial", longint'(got.size()), 64'sd0);
        for (int i = 0; i < 60; i++) step($urandom_range(0, 3) != 0, rnd(10));
        flush();
        compare_model("midrst_after");

        // Parameter sweep with random data and occasional gaps.
        for (int s = 1; s <= 3; s++) begin
            select_cfg(s);
            reset_dut();
            for (int i = 0; i < 12 * cr; i++) step($urandom_range(0, 3) != 0, rnd(ciw));
            flush();
            compare_model($sformatf("sweep%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
